// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional feature macro: BIN2BCD_SIGNED_EN (two's complement input).
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ADD3_THRESH = 4'd5;
    localparam bcd_digit_t ADD3        = 4'd3;

    // Decimal digits needed to hold 2^bin_w - 1 without overflow.
    function automatic int min_digits(input int bin_w);
        longint unsigned v;
        int n;
        v = (64'd1 << bin_w) - 64'd1;
        n = 0;
        while (v != 0) begin
            v = v / 10;
            n = n + 1;
        end
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_dabble_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_dabble_digit
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Pre-shift correction, purely combinational.
    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH) begin
            dout = din + ADD3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// valid/ready on both sides. Optional macro BIN2BCD_SIGNED_EN: signed input.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  sign
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;
    localparam logic OVF_POSSIBLE = (DIGITS < min_digits(BIN_W));

    if (BIN_W < 2 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin2bcd_seq: BIN_W must be in 2..32");
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS must be in 1..10");
    end

    state_e            state_q, state_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]  dig_q, dig_d;
    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  dig_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_w_q, ovf_w_d;
    logic              ovf_nxt;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic [BIN_W-1:0]  load_val;
    logic              accept;
    logic              last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_dabble_digit u_dig (
            .din  (dig_q[4*i +: 4]),
            .dout (adj[4*i +: 4])
        );
    end

`ifdef BIN2BCD_SIGNED_EN
    logic sign_w_q, sign_w_d;
    logic sign_q, sign_d;

    // Magnitude of a two's complement input; the most negative value
    // maps onto 2^(BIN_W-1), which still fits BIN_W unsigned bits.
    assign load_val = bin[BIN_W-1] ? (~bin + BIN_W'(1)) : bin;
    assign sign     = sign_q;
`else
    assign load_val = bin;
    assign sign     = 1'b0;
`endif

    assign accept  = in_valid && in_ready;
    assign last    = (cnt_q == '0);
    assign dig_nxt = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
    assign ovf_nxt = ovf_w_q | (adj[BCD_W-1] & OVF_POSSIBLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Load on accept, one dabble step per SHIFT cycle, latch result at the end.
    always_comb begin
        shift_d = shift_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        ovf_w_d = ovf_w_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
        sign_w_d = sign_w_q;
        sign_d   = sign_q;
`endif
        if (accept) begin
            shift_d = load_val;
            dig_d   = '0;
            ovf_w_d = 1'b0;
            cnt_d   = CNT_W'(BIN_W - 1);
`ifdef BIN2BCD_SIGNED_EN
            sign_w_d = bin[BIN_W-1];
`endif
        end else if (state_q == SHIFT) begin
            shift_d = {shift_q[BIN_W-2:0], 1'b0};
            dig_d   = dig_nxt;
            ovf_w_d = ovf_nxt;
            if (last) begin
                bcd_d = dig_nxt;
                ovf_d = ovf_nxt;
`ifdef BIN2BCD_SIGNED_EN
                sign_d = sign_w_q;
`endif
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            ovf_w_q <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            ovf_w_q <= ovf_w_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    // Sign travels with the conversion and is published with bcd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_w_q <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            sign_w_q <= sign_w_d;
            sign_q   <= sign_d;
        end
    end
`endif

    assign bcd = bcd_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: default (16b/5 digits) and a 4-digit instance
// driven in lockstep, checked against an arithmetic decimal model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] bin;

    logic        in_ready, out_valid, ovf, sign;
    logic [19:0] bcd;
    logic        in_ready4, out_valid4, ovf4, sign4;
    logic [15:0] bcd4;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .bcd(bcd), .ovf(ovf), .sign(sign)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4), .bin(bin),
        .out_valid(out_valid4), .out_ready(out_ready),
        .bcd(bcd4), .ovf(ovf4), .sign(sign4)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Decimal digits of v, least significant first, truncated to nd digits.
    function automatic logic [39:0] ref_bcd(input longint unsigned v,
                                            input int nd);
        logic [39:0] r = '0;
        longint unsigned t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic longint unsigned mag_of(input logic [15:0] b);
`ifdef BIN2BCD_SIGNED_EN
        if (b[15]) return longint'(65536 - int'(b));
`endif
        return longint'(b);
    endfunction

    function automatic logic sign_of(input logic [15:0] b);
`ifdef BIN2BCD_SIGNED_EN
        return b[15];
`else
        return 1'b0 & b[15];
`endif
    endfunction

    task automatic conv(input logic [15:0] b, input int hold);
        int lat;
        logic busy_rdy;
        longint unsigned m;
        logic [39:0] e5, e4;
        logic [19:0] held;
        m  = mag_of(b);
        e5 = ref_bcd(m, 5);
        e4 = ref_bcd(m, 4);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        bin = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_rdy = 1'b1;
            bin = 16'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 16);
        chk("in_ready_busy", busy_rdy, 0);
        chk("bcd", bcd, e5[19:0]);
        chk("ovf", ovf, (m >= pow10(5)));
        chk("sign", sign, sign_of(b));
        chk("out_valid4", out_valid4, 1);
        chk("bcd4", bcd4, e4[15:0]);
        chk("ovf4", ovf4, (m >= pow10(4)));
        held = bcd;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_bcd", bcd, e5[19:0]);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("ready_back", in_ready, 1);
        chk("bcd_retained", bcd, held);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        bin = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sign", sign, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        conv(16'd65535, 0);
        conv(16'd0, 0);
        conv(16'd9, 0);
        conv(16'd40000, 5);
        conv(16'd12345, 0);
        conv(16'd9999, 0);
        conv(16'hFB2E, 0);
        conv(16'h8000, 0);
        conv(16'd77, 2);
        for (int i = 0; i < 20; i++) begin
            conv(16'($urandom), int'($urandom_range(0, 3)));
        end

        conv(16'd4321, 0);
        @(negedge clk);
        bin = 16'd600;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_bcd", bcd, 0);
        chk("abort_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        conv(16'd500, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
